// File: rtl/reg_xfer_ctrl_if.sv
// Request/status bundle for reg_xfer_ctrl. Optional load-port signals exist
// only when REG_XFER_LOAD_EN is defined.
interface reg_xfer_ctrl_if;
    logic       start;
    logic [1:0] op;
    logic [1:0] src;
    logic [1:0] dst;
    logic [3:0] a_out;
    logic [3:0] b_out;
    logic [3:0] c_out;
    logic [3:0] bus_out;
    logic       busy;
    logic       done;
    logic       err;
`ifdef REG_XFER_LOAD_EN
    logic       ld_en;
    logic [1:0] ld_sel;
    logic [3:0] ld_data;

    modport master (
        output start, op, src, dst, ld_en, ld_sel, ld_data,
        input  a_out, b_out, c_out, bus_out, busy, done, err
    );
    modport slave (
        input  start, op, src, dst, ld_en, ld_sel, ld_data,
        output a_out, b_out, c_out, bus_out, busy, done, err
    );
`else
    modport master (
        output start, op, src, dst,
        input  a_out, b_out, c_out, bus_out, busy, done, err
    );
    modport slave (
        input  start, op, src, dst,
        output a_out, b_out, c_out, bus_out, busy, done, err
    );
`endif
endinterface

// File: rtl/reg_xfer_ctrl.sv
// Three-register transfer controller (MOVE/SWAP/INC/DEC over one shared bus).
// Define REG_XFER_LOAD_EN to add the direct register load port.
module reg_xfer_ctrl (
    input  logic              clk,
    input  logic              rst_n,
    reg_xfer_ctrl_if.slave    xf
);
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        S1   = 3'd1,
        S2   = 3'd2,
        S3   = 3'd3,
        DONE = 3'd4
    } state_t;

    localparam logic [1:0] OP_MOVE = 2'd0;
    localparam logic [1:0] OP_SWAP = 2'd1;
    localparam logic [1:0] OP_INC  = 2'd2;
    localparam logic [1:0] OP_DEC  = 2'd3;

    state_t     state_r;
    state_t     state_s;
    logic [1:0] op_r;
    logic [1:0] src_r;
    logic [1:0] dst_r;
    logic [3:0] a_r;
    logic [3:0] b_r;
    logic [3:0] c_r;
    logic       busy_r;
    logic       done_r;
    logic       err_r;

    logic [3:0] bus_s;
    logic       wr_en_s;
    logic [1:0] wr_sel_s;
    logic       accept_s;
    logic       reject_s;
    logic [1:0] tmp_idx_s;
    logic       load_s;
    logic [1:0] ld_sel_s;
    logic [3:0] ld_data_s;

    function automatic logic [3:0] rd_reg(input logic [1:0] idx,
                                          input logic [3:0] ra,
                                          input logic [3:0] rb,
                                          input logic [3:0] rc);
        logic [3:0] val;
        case (idx)
            2'd0:    val = ra;
            2'd1:    val = rb;
            2'd2:    val = rc;
            default: val = 4'd0;
        endcase
        return val;
    endfunction

    function automatic logic req_invalid(input logic [1:0] op,
                                         input logic [1:0] src,
                                         input logic [1:0] dst);
        logic src_used;
        src_used = (op == OP_MOVE) || (op == OP_SWAP);
        return (dst == 2'd3) ||
               (src_used && (src == 2'd3)) ||
               ((op == OP_SWAP) && (src == dst));
    endfunction

`ifdef REG_XFER_LOAD_EN
    assign load_s    = xf.ld_en && (xf.ld_sel != 2'd3);
    assign ld_sel_s  = xf.ld_sel;
    assign ld_data_s = xf.ld_data;
`else
    assign load_s    = 1'b0;
    assign ld_sel_s  = 2'd0;
    assign ld_data_s = 4'd0;
`endif

    // SWAP parks reg[src] in the register named by neither operand
    assign tmp_idx_s = 2'd3 - src_r - dst_r;

    // Next-state, bus source and single register write-port selection
    always_comb begin
        state_s  = state_r;
        bus_s    = 4'd0;
        wr_en_s  = 1'b0;
        wr_sel_s = 2'd0;
        accept_s = 1'b0;
        reject_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (load_s) begin
                    wr_en_s  = 1'b1;
                    wr_sel_s = ld_sel_s;
                    bus_s    = ld_data_s;
                end else if (xf.start) begin
                    accept_s = 1'b1;
                    if (req_invalid(xf.op, xf.src, xf.dst)) begin
                        reject_s = 1'b1;
                        state_s  = DONE;
                    end else begin
                        state_s  = S1;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            S1: begin
                wr_en_s = 1'b1;
                case (op_r)
                    OP_MOVE: begin
                        bus_s    = rd_reg(src_r, a_r, b_r, c_r);
                        wr_sel_s = dst_r;
                        state_s  = DONE;
                    end
                    OP_SWAP: begin
                        bus_s    = rd_reg(src_r, a_r, b_r, c_r);
                        wr_sel_s = tmp_idx_s;
                        state_s  = S2;
                    end
                    OP_INC: begin
                        bus_s    = rd_reg(dst_r, a_r, b_r, c_r) + 4'd1;
                        wr_sel_s = dst_r;
                        state_s  = DONE;
                    end
                    OP_DEC: begin
                        bus_s    = rd_reg(dst_r, a_r, b_r, c_r) - 4'd1;
                        wr_sel_s = dst_r;
                        state_s  = DONE;
                    end
                    default: begin
                        wr_en_s = 1'b0;
                        state_s = DONE;
                    end
                endcase
            end
            S2: begin
                wr_en_s  = 1'b1;
                bus_s    = rd_reg(dst_r, a_r, b_r, c_r);
                wr_sel_s = src_r;
                state_s  = S3;
            end
            S3: begin
                wr_en_s  = 1'b1;
                bus_s    = rd_reg(tmp_idx_s, a_r, b_r, c_r);
                wr_sel_s = dst_r;
                state_s  = DONE;
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State register and registered status flags aligned with the new state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s != IDLE);
            done_r  <= (state_s == DONE);
            err_r   <= reject_s;
        end
    end

    // Request capture at the accepting edge
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_r  <= 2'd0;
            src_r <= 2'd0;
            dst_r <= 2'd0;
        end else if (accept_s) begin
            op_r  <= xf.op;
            src_r <= xf.src;
            dst_r <= xf.dst;
        end
    end

    // Register file: one write per cycle, always sourced from the bus
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_r <= 4'd0;
            b_r <= 4'd0;
            c_r <= 4'd0;
        end else if (wr_en_s) begin
            case (wr_sel_s)
                2'd0:    a_r <= bus_s;
                2'd1:    b_r <= bus_s;
                2'd2:    c_r <= bus_s;
                default: a_r <= a_r;
            endcase
        end
    end

    assign xf.a_out   = a_r;
    assign xf.b_out   = b_r;
    assign xf.c_out   = c_r;
    assign xf.bus_out = bus_s;
    assign xf.busy    = busy_r;
    assign xf.done    = done_r;
    assign xf.err     = err_r;
endmodule

// File: tb/tb_reg_xfer_ctrl.sv
// Self-checking bench for reg_xfer_ctrl: directed scenarios plus random ops
// compared cycle by cycle against an operation-level reference model.
module tb_reg_xfer_ctrl;
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    reg_xfer_ctrl_if xf ();

    reg_xfer_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .xf    (xf)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int m[3];

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_regs(input string tag);
        check({tag, ".a"}, {4'd0, xf.a_out}, 8'(m[0]));
        check({tag, ".b"}, {4'd0, xf.b_out}, 8'(m[1]));
        check({tag, ".c"}, {4'd0, xf.c_out}, 8'(m[2]));
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".busy"}, {7'd0, xf.busy}, 8'd0);
        check({tag, ".done"}, {7'd0, xf.done}, 8'd0);
        check({tag, ".err"},  {7'd0, xf.err},  8'd0);
        check({tag, ".bus"},  {4'd0, xf.bus_out}, 8'd0);
        check_regs(tag);
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        xf.start = 1'b0;
        tick();
        tick();
        m = '{0, 0, 0};
        check_idle("reset");
        rst_n = 1'b1;
    endtask

    // noise: 0 = start low while busy, 1 = random start, 2 = start held high
    task automatic do_op(input logic [1:0] o, input logic [1:0] s,
                         input logic [1:0] d, input int noise);
        int  eb[3];
        int  nm[3];
        int  n;
        int  t;
        bit  inv;
        inv = (d == 2'd3) || ((o == 2'd0 || o == 2'd1) && s == 2'd3) ||
              (o == 2'd1 && s == d);
        nm = m;
        n  = 0;
        if (!inv) begin
            case (o)
                2'd0: begin n = 1; eb[0] = m[s]; nm[d] = m[s]; end
                2'd2: begin n = 1; eb[0] = (m[d] + 1) % 16; nm[d] = eb[0]; end
                2'd3: begin n = 1; eb[0] = (m[d] + 15) % 16; nm[d] = eb[0]; end
                default: begin
                    t = 3 - int'(s) - int'(d);
                    n = 3;
                    eb[0] = m[s]; eb[1] = m[d]; eb[2] = m[s];
                    nm[t] = m[s]; nm[s] = m[d]; nm[d] = m[s];
                end
            endcase
        end
        xf.start = 1'b1;
        xf.op    = o;
        xf.src   = s;
        xf.dst   = d;
        tick();
        for (int i = 0; i < n; i++) begin
            check("act.busy", {7'd0, xf.busy}, 8'd1);
            check("act.done", {7'd0, xf.done}, 8'd0);
            check("act.err",  {7'd0, xf.err},  8'd0);
            check("act.bus",  {4'd0, xf.bus_out}, 8'(eb[i]));
            xf.start = (noise == 2) ? 1'b1 : (noise == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            xf.op    = 2'($urandom_range(0, 3));
            xf.src   = 2'($urandom_range(0, 3));
            xf.dst   = 2'($urandom_range(0, 3));
            tick();
        end
        check("done.busy", {7'd0, xf.busy}, 8'd1);
        check("done.done", {7'd0, xf.done}, 8'd1);
        check("done.err",  {7'd0, xf.err},  {7'd0, inv});
        check("done.bus",  {4'd0, xf.bus_out}, 8'd0);
        m = nm;
        check_regs("done");
        xf.start = 1'b0;
        tick();
        check_idle("after");
    endtask

    initial begin
        rst_n    = 1'b0;
        xf.start = 1'b0;
        xf.op    = 2'd0;
        xf.src   = 2'd0;
        xf.dst   = 2'd0;
`ifdef REG_XFER_LOAD_EN
        xf.ld_en   = 1'b0;
        xf.ld_sel  = 2'd0;
        xf.ld_data = 4'd0;
`endif
        do_reset();

        // INC A twice: a=1 then 2
        do_op(2'd2, 2'd0, 2'd0, 0);
        check("inc1.a", {4'd0, xf.a_out}, 8'd1);
        do_op(2'd2, 2'd3, 2'd0, 0);
        check("inc2.a", {4'd0, xf.a_out}, 8'd2);

        // DEC B wraps to F, INC B wraps to 0
        do_reset();
        do_op(2'd3, 2'd0, 2'd1, 0);
        check("dec.b", {4'd0, xf.b_out}, 8'h0f);
        do_op(2'd2, 2'd0, 2'd1, 0);
        check("incwrap.b", {4'd0, xf.b_out}, 8'h00);

        // A=3, B=5 then SWAP A<->B with start held high throughout
        do_reset();
        for (int i = 0; i < 3; i++) do_op(2'd2, 2'd0, 2'd0, 0);
        for (int i = 0; i < 5; i++) do_op(2'd2, 2'd0, 2'd1, 0);
        do_op(2'd1, 2'd0, 2'd1, 2);
        check("swap.a", {4'd0, xf.a_out}, 8'd5);
        check("swap.b", {4'd0, xf.b_out}, 8'd3);
        check("swap.c", {4'd0, xf.c_out}, 8'd3);

        // Invalid request: MOVE C -> 3
        do_op(2'd0, 2'd2, 2'd3, 0);
        check("inv.a", {4'd0, xf.a_out}, 8'd5);

        // Reset during SWAP S2 aborts with no done
        xf.start = 1'b1;
        xf.op    = 2'd1;
        xf.src   = 2'd0;
        xf.dst   = 2'd1;
        tick();
        xf.start = 1'b0;
        check("rst.s1busy", {7'd0, xf.busy}, 8'd1);
        tick();
        check("rst.s2bus", {4'd0, xf.bus_out}, 8'd3);
        rst_n = 1'b0;
        tick();
        m = '{0, 0, 0};
        check_idle("rstmid");
        rst_n = 1'b1;
        tick();
        check_idle("rstpost");

        // Random operations with random in-flight start noise
        for (int k = 0; k < 300; k++) begin
            do_op(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                  2'($urandom_range(0, 3)), int'($urandom_range(0, 1)));
            if ($urandom_range(0, 49) == 0) do_reset();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
